// File: rtl/miner_nonce_dispatcher.sv
// miner_nonce_dispatcher
//   Nonce-search controller. Accepts a job (inclusive nonce range + target),
//   hands nonces one per cycle to NUM_LANES external hashing lanes, compares
//   each returned digest against the target (hit when digest <= target,
//   unsigned) and offers winning nonces on a one-deep valid/ready port.
//
// Ports
//   CLOCK_50, reset_n          clock (rising edge), async active-low reset
//   job_valid/job_ready        job handshake; ready only while idle
//   job_nonce_start/_end       inclusive nonce range, may wrap through 0
//   job_target                 hit threshold
//   job_abort                  cancel the running job (RUN only)
//   lane_start/lane_nonce      one-cycle start pulse and nonce per lane
//   lane_done/lane_digest      one-cycle result pulse and digest per lane
//   found_valid/ready/nonce    winning nonce output
//   hit_overflow               sticky per job: a hit was dropped
//   job_done                   one-cycle pulse, job over and all lanes idle
//   busy, hash_count, led      status
//
// Build option
//   MINER_LED_STATUS_EN  drives led with {activity bar, hit_overflow,
//                        found_valid, busy}; otherwise led is tied to 0.
module miner_nonce_dispatcher #(
  parameter int NUM_LANES = 4,
  parameter int NONCE_W   = 32,
  parameter int DIGEST_W  = 256,
  parameter int LED_W     = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [NONCE_W-1:0]            job_nonce_start,
  input  logic [NONCE_W-1:0]            job_nonce_end,
  input  logic [DIGEST_W-1:0]           job_target,
  input  logic                          job_abort,
  output logic [NUM_LANES-1:0]          lane_start,
  output logic [NUM_LANES*NONCE_W-1:0]  lane_nonce,
  input  logic [NUM_LANES-1:0]          lane_done,
  input  logic [NUM_LANES*DIGEST_W-1:0] lane_digest,
  output logic                          found_valid,
  input  logic                          found_ready,
  output logic [NONCE_W-1:0]            found_nonce,
  output logic                          hit_overflow,
  output logic                          job_done,
  output logic                          busy,
  output logic [31:0]                   hash_count,
  output logic [LED_W-1:0]              led
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  localparam int CNT_W = $clog2(NUM_LANES + 1);

  state_e                         state_q, state_d;
  logic [NONCE_W-1:0]             next_q, next_d;
  logic [NONCE_W-1:0]             end_q, end_d;
  logic [DIGEST_W-1:0]            target_q, target_d;
  logic                           aborted_q, aborted_d;
  logic [NUM_LANES-1:0]           lane_busy_q, lane_busy_d;
  logic [NUM_LANES-1:0]           lane_start_q, lane_start_d;
  logic [NUM_LANES*NONCE_W-1:0]   lane_nonce_q, lane_nonce_d;
  logic                           found_valid_q, found_valid_d;
  logic [NONCE_W-1:0]             found_nonce_q, found_nonce_d;
  logic                           hit_overflow_q, hit_overflow_d;
  logic                           job_done_q, job_done_d;
  logic [31:0]                    hash_count_q, hash_count_d;

  logic [NUM_LANES-1:0]           done_vec;
  logic [NUM_LANES-1:0]           hit_vec;
  logic [32:0]                    hash_sum;
  logic                           slot_free;
  logic                           hit_taken;
  logic                           dispatched;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LANES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d        = state_q;
    next_d         = next_q;
    end_d          = end_q;
    target_d       = target_q;
    aborted_d      = aborted_q;
    lane_nonce_d   = lane_nonce_q;
    lane_start_d   = '0;
    job_done_d     = 1'b0;
    found_valid_d  = found_valid_q;
    found_nonce_d  = found_nonce_q;
    hit_overflow_d = hit_overflow_q;
    hit_vec        = '0;
    hit_taken      = 1'b0;
    dispatched     = 1'b0;

    // Results on idle lanes are stale or spurious and are ignored entirely.
    done_vec    = lane_done & lane_busy_q;
    lane_busy_d = lane_busy_q & ~done_vec;

    hash_sum     = {1'b0, hash_count_q} + 33'(popcount(done_vec));
    hash_count_d = hash_sum[32] ? 32'hFFFF_FFFF : hash_sum[31:0];

    // After an abort the in-flight results are only counted, never judged.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (done_vec[i] && !aborted_q &&
          (lane_digest[i*DIGEST_W +: DIGEST_W] <= target_q)) begin
        hit_vec[i] = 1'b1;
      end
    end

    // The buffer is free for a new hit if empty or handed off this cycle.
    slot_free = !found_valid_q || found_ready;
    if (found_valid_q && found_ready) found_valid_d = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (hit_vec[i]) begin
        if (!hit_taken && slot_free) begin
          found_valid_d = 1'b1;
          found_nonce_d = lane_nonce_q[i*NONCE_W +: NONCE_W];
        end else begin
          hit_overflow_d = 1'b1;
        end
        hit_taken = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          state_d        = ST_RUN;
          next_d         = job_nonce_start;
          end_d          = job_nonce_end;
          target_d       = job_target;
          aborted_d      = 1'b0;
          hash_count_d   = '0;
          hit_overflow_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (job_abort) begin
          state_d   = ST_DRAIN;
          aborted_d = 1'b1;
        end else if (slot_free) begin
          // Lanes freed this cycle are still busy in lane_busy_q, so a lane
          // never gets a new nonce on the same edge its result returns.
          for (int i = 0; i < NUM_LANES; i++) begin
            if (!lane_busy_q[i] && !dispatched) begin
              dispatched                          = 1'b1;
              lane_start_d[i]                     = 1'b1;
              lane_busy_d[i]                      = 1'b1;
              lane_nonce_d[i*NONCE_W +: NONCE_W]  = next_q;
              next_d                              = next_q + NONCE_W'(1);
              if (next_q == end_q) state_d = ST_DRAIN;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (lane_busy_d == '0) begin
          state_d    = ST_IDLE;
          job_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: all registers, including the wide nonce and target holders, are
  // reset so a mid-job reset leaves no trace of the previous job.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q        <= ST_IDLE;
      next_q         <= '0;
      end_q          <= '0;
      target_q       <= '0;
      aborted_q      <= 1'b0;
      lane_busy_q    <= '0;
      lane_start_q   <= '0;
      lane_nonce_q   <= '0;
      found_valid_q  <= 1'b0;
      found_nonce_q  <= '0;
      hit_overflow_q <= 1'b0;
      job_done_q     <= 1'b0;
      hash_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      next_q         <= next_d;
      end_q          <= end_d;
      target_q       <= target_d;
      aborted_q      <= aborted_d;
      lane_busy_q    <= lane_busy_d;
      lane_start_q   <= lane_start_d;
      lane_nonce_q   <= lane_nonce_d;
      found_valid_q  <= found_valid_d;
      found_nonce_q  <= found_nonce_d;
      hit_overflow_q <= hit_overflow_d;
      job_done_q     <= job_done_d;
      hash_count_q   <= hash_count_d;
    end
  end

  assign job_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign lane_start   = lane_start_q;
  assign lane_nonce   = lane_nonce_q;
  assign found_valid  = found_valid_q;
  assign found_nonce  = found_nonce_q;
  assign hit_overflow = hit_overflow_q;
  assign job_done     = job_done_q;
  assign hash_count   = hash_count_q;

`ifdef MINER_LED_STATUS_EN
  if (LED_W > 3) begin : g_led_bar
    assign led = {(LED_W-3)'(hash_count_q >> 26), hit_overflow_q, found_valid_q, busy};
  end else begin : g_led_min
    assign led = {hit_overflow_q, found_valid_q, busy};
  end
`else
  assign led = '0;
`endif

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Testbench for miner_nonce_dispatcher: four lane models with a fixed
// latency, directed jobs, and scoreboards for dispatched and found nonces.
module tb_miner_nonce_dispatcher;

  localparam int NL = 4;
  localparam int NW = 32;
  localparam int DW = 256;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              job_valid;
  logic              job_ready;
  logic [NW-1:0]     job_nonce_start;
  logic [NW-1:0]     job_nonce_end;
  logic [DW-1:0]     job_target;
  logic              job_abort;
  logic [NL-1:0]     lane_start;
  logic [NL*NW-1:0]  lane_nonce;
  logic [NL-1:0]     lane_done;
  logic [NL*DW-1:0]  lane_digest;
  logic              found_valid;
  logic              found_ready;
  logic [NW-1:0]     found_nonce;
  logic              hit_overflow;
  logic              job_done;
  logic              busy;
  logic [31:0]       hash_count;
  logic [LW-1:0]     led;

  logic [NL-1:0]     inj_done;

  logic [NW-1:0]     exp_disp[$];
  logic [NW-1:0]     exp_found[$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                disp_cnt = 0;
  int                jd_cnt   = 0;

  always #5 clk = ~clk;

  miner_nonce_dispatcher #(
    .NUM_LANES(NL), .NONCE_W(NW), .DIGEST_W(DW), .LED_W(LW)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .job_valid(job_valid),
    .job_ready(job_ready),
    .job_nonce_start(job_nonce_start),
    .job_nonce_end(job_nonce_end),
    .job_target(job_target),
    .job_abort(job_abort),
    .lane_start(lane_start),
    .lane_nonce(lane_nonce),
    .lane_done(lane_done),
    .lane_digest(lane_digest),
    .found_valid(found_valid),
    .found_ready(found_ready),
    .found_nonce(found_nonce),
    .hit_overflow(hit_overflow),
    .job_done(job_done),
    .busy(busy),
    .hash_count(hash_count),
    .led(led)
  );

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Digest is zero only for nonce 0x25, otherwise large and nonzero.
  function automatic logic [DW-1:0] digest_of(input logic [NW-1:0] n);
    return (n == 32'h25) ? '0 : {n, 224'd1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_disp(input logic [NW-1:0] s, input logic [NW-1:0] e);
    logic [NW-1:0] n;
    n = s;
    forever begin
      exp_disp.push_back(n);
      if (n == e) break;
      n = n + 32'd1;
    end
  endtask

  task automatic start_job(input logic [NW-1:0] s, input logic [NW-1:0] e, input logic [DW-1:0] t);
    job_nonce_start = s;
    job_nonce_end   = e;
    job_target      = t;
    job_valid       = 1'b1;
    tick();
    job_valid       = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_hc, input int exp_jobs);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!job_done && n < 400);
    check({name, "_done_seen"}, job_done, 1);
    if (job_done) check({name, "_hash_count"}, hash_count, exp_hc);
    @(negedge clk);
    check({name, "_done_pulse"}, job_done, 0);
    check({name, "_done_count"}, jd_cnt, exp_jobs);
    tick();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_job_ready"},    job_ready, 1);
    check({name, "_busy"},         busy, 0);
    check({name, "_lane_start"},   lane_start, 0);
    check({name, "_lane_nonce0"},  lane_nonce == '0, 1);
    check({name, "_found_valid"},  found_valid, 0);
    check({name, "_found_nonce"},  found_nonce, 0);
    check({name, "_hit_overflow"}, hit_overflow, 0);
    check({name, "_job_done"},     job_done, 0);
    check({name, "_hash_count"},   hash_count, 0);
    check({name, "_led"},          led, 0);
  endtask

  // Lane models: a start seen at a falling edge returns its digest three
  // falling edges later, as a one-cycle done pulse.
  initial begin
    int            cnt[NL];
    logic [NW-1:0] hold[NL];
    lane_done   = '0;
    lane_digest = '0;
    for (int i = 0; i < NL; i++) begin
      cnt[i]  = 0;
      hold[i] = '0;
    end
    forever begin
      @(negedge clk);
      lane_done = '0;
      if (!reset_n) begin
        for (int i = 0; i < NL; i++) cnt[i] = 0;
      end else begin
        for (int i = 0; i < NL; i++) begin
          if (cnt[i] != 0) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              lane_done[i]              = 1'b1;
              lane_digest[i*DW +: DW]   = digest_of(hold[i]);
            end
          end
          if (lane_start[i]) begin
            cnt[i]  = 3;
            hold[i] = lane_nonce[i*NW +: NW];
          end
          if (inj_done[i]) begin
            lane_done[i]            = 1'b1;
            lane_digest[i*DW +: DW] = '0;
          end
        end
      end
    end
  end

  // Dispatch monitor.
  initial forever begin
    @(negedge clk);
    if (reset_n && lane_start != '0) begin
      check("one_dispatch_per_cycle", $countones(lane_start) <= 1, 1);
      for (int i = 0; i < NL; i++) begin
        if (lane_start[i]) begin
          disp_cnt++;
          if (exp_disp.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_dispatch: lane %0d got nonce 0x%0h, expected none", i, lane_nonce[i*NW +: NW]);
          end else begin
            check("lane_nonce", lane_nonce[i*NW +: NW], exp_disp.pop_front());
          end
        end
      end
    end
  end

  // Found-nonce monitor.
  initial forever begin
    @(negedge clk);
    if (reset_n && found_valid && found_ready) begin
      if (exp_found.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_found: got 0x%0h, expected none", found_nonce);
      end else begin
        check("found_nonce", found_nonce, exp_found.pop_front());
      end
    end
  end

  // job_done pulse counter.
  initial forever begin
    @(negedge clk);
    if (reset_n && job_done) jd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    reset_n         = 1'b0;
    job_valid       = 1'b0;
    job_nonce_start = '0;
    job_nonce_end   = '0;
    job_target      = '0;
    job_abort       = 1'b0;
    found_ready     = 1'b0;
    inj_done        = '0;
    repeat (3) tick();
    check_reset_values("por");
    reset_n = 1'b1;
    tick();

    // Job 1: every nonce hits, consumer always ready.
    found_ready = 1'b1;
    push_disp(32'h10, 32'h1F);
    for (int n = 'h10; n <= 'h1F; n++) exp_found.push_back(32'(n));
    start_job(32'h10, 32'h1F, '1);
    check("job1_busy", busy, 1);
    check("job1_job_ready", job_ready, 0);
`ifdef MINER_LED_STATUS_EN
    check("job1_led0_busy", led[0], 1);
`else
    check("job1_led_zero", led, 0);
`endif
    wait_done("job1", 32'd16, 1);
    check("job1_hit_overflow", hit_overflow, 0);
    check("idle_led", led, 0);

    // Done pulse on an idle lane with a winning digest must be ignored.
    inj_done = 4'b0100;
    tick();
    inj_done = '0;
    tick();
    tick();
    check("idle_done_hash_count", hash_count, 16);
    check("idle_done_found_valid", found_valid, 0);

    // Job 2: range wraps through all-ones.
    push_disp(32'hFFFF_FFFE, 32'h1);
    exp_found.push_back(32'hFFFF_FFFE);
    exp_found.push_back(32'hFFFF_FFFF);
    exp_found.push_back(32'h0);
    exp_found.push_back(32'h1);
    start_job(32'hFFFF_FFFE, 32'h1, '1);
    wait_done("job2", 32'd4, 2);

    // Job 3: target 0, only nonce 0x25 hits.
    push_disp(32'h20, 32'h2F);
    exp_found.push_back(32'h25);
    start_job(32'h20, 32'h2F, '0);
    wait_done("job3", 32'd16, 3);

    // Job 4: consumer stalled; dispatch must stop and later hits drop.
    found_ready = 1'b0;
    push_disp(32'h0, 32'h7);
    exp_found.push_back(32'h0);
    for (int n = 4; n <= 7; n++) exp_found.push_back(32'(n));
    d0 = disp_cnt;
    start_job(32'h0, 32'h7, '1);
    repeat (12) tick();
    check("stall_dispatches", disp_cnt - d0, 4);
    check("stall_found_valid", found_valid, 1);
    check("stall_found_nonce", found_nonce, 0);
    check("stall_hit_overflow", hit_overflow, 1);
    repeat (5) tick();
    check("stall_still_held", disp_cnt - d0, 4);
    found_ready = 1'b1;
    wait_done("job4", 32'd8, 4);
    check("job4_dispatches", disp_cnt - d0, 8);
    check("job4_hit_overflow_sticky", hit_overflow, 1);

    // Job 5: abort after two dispatches; returns are counted, not compared.
    push_disp(32'h0, 32'h1);
    start_job(32'h0, 32'hFF, '1);
    check("job5_overflow_cleared", hit_overflow, 0);
    tick();
    tick();
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    wait_done("abort", 32'd2, 5);

    // Abort while idle has no effect.
    job_abort = 1'b1;
    tick();
    job_abort = 1'b0;
    tick();
    check("idle_abort_ready", job_ready, 1);
    check("idle_abort_busy", busy, 0);

    // Reset in the middle of a job.
    push_disp(32'h0, 32'h1);
    start_job(32'h0, 32'hFF, '1);
    tick();
    tick();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check("post_reset_job_ready", job_ready, 1);
    check("post_reset_hash_count", hash_count, 0);
    check("post_reset_found_valid", found_valid, 0);

    check("disp_queue_empty", exp_disp.size(), 0);
    check("found_queue_empty", exp_found.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
